ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
- PS/2 device-to-host receiver. Oversamples the keyboard's ps2_clk/ps2_data with the system clock and deframes 11-bit PS/2 frames.
- Valid scan-code bytes are pushed into a small FIFO. The host reads them through a ready / nextdata_n handshake.
- Sits between the board's PS/2 pins and the keyboard-controller / scan-code decoding logic.

Parameters:
- FIFO_DEPTH, 8, number of byte entries in the receive FIFO; must be a power of two, at least 2.
- SYNC_STAGES, 3, length of the ps2_clk synchronizer shift register; at least 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- clrn  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data from the keyboard.
- nextdata_n  in  1  active-low read strobe from the host.
- data  out  8  byte at the FIFO head; valid while ready=1.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky flag: a valid frame was lost because the FIFO was full.

Behaviour:
- Reset (clrn=0, asynchronous) clears:
  - synchronizer to all ones;
  - bit counter to 0 and shift buffer to 0;
  - FIFO pointers and occupancy to 0.
  - Resulting outputs: ready=0, overflow=0, data=8'h00 (FIFO storage cleared).
- Reset mid-frame discards the partial frame. The next frame is received normally.
- ps2_clk passes through a SYNC_STAGES shift register.
  - Falling edge = the oldest stage is 1 and the next-newer stage is 0. This gives a one-cycle strobe.
  - ps2_clk must stay in each level for at least 3 clk cycles. Narrower pulses are not required to be detected.
- On each falling-edge strobe, sample ps2_data into buffer[count].
  - count runs 0..10: start bit, d0..d7 LSB first, parity, stop.
  - count increments after each sample and returns to 0 after bit 10.
- On the strobe where count==10, check:
  - buffer[0]==0 (start bit);
  - the sampled stop bit==1;
  - odd parity: XOR of d0..d7 and the parity bit ==1.
- Frame valid: push byte d7..d0 into the FIFO.
- Frame invalid: discard silently. No flag is raised and count still returns to 0.
- Push timing: write happens on the same clk edge that samples the stop bit; ready=1 from the following cycle.
- Pop: on any clk edge with nextdata_n=0 and ready=1, the read pointer advances by one.
  - Level-sensitive: one byte per cycle while nextdata_n is held low.
  - nextdata_n=0 with the FIFO empty has no effect.
  - An unknown/1 nextdata_n means no pop.
- data is combinationally FIFO[read pointer]. ready is 1 whenever occupancy > 0.
- Push and pop on the same edge: both take effect and occupancy is unchanged.
- Full FIFO (occupancy == FIFO_DEPTH) with a valid frame and no simultaneous pop:
  - byte dropped, existing contents untouched;
  - overflow set to 1 and held until clrn.
- Full FIFO with a simultaneous pop: the push succeeds and no overflow is raised.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package ps2_pkg holds:
  - PS2_FRAME_BITS=11;
  - bit indices START_IDX=0, PARITY_IDX=9, STOP_IDX=10;
  - default FIFO_DEPTH.
- Natural sub-module: ps2_rx_fifo, a parameterized synchronous FIFO.
  - Ports: push, push_data, pop, head_data, empty, full.
  - The top keeps the synchronizer, edge detector, bit counter, frame checker and overflow flag.

Test Plan:
- Reset, then clock-generator period 10 ns, ps2_clk half-period 30 ns. Send bits 0,1,0,1,1,1,1,1,1,0,1 (start, d0..d7, parity=0, stop) -> ready=1 and data=8'hFD, overflow=0. Then pulse nextdata_n low for 2 cycles -> ready=0 and the FIFO is empty.
- Send 8'h1C, 8'hF0, 8'h1C, 8'h1B with no reads -> data steps 1C, F0, 1C, 1B on successive pops; ready drops after the 4th pop.
- Send 8'h1C with the parity bit flipped -> ready stays 0. Repeat with start=1, then with stop=0 -> ready stays 0 each time. A following good 8'h1B frame -> data=8'h1B.
- Send 9 valid frames 8'h01..8'h09 without reading -> overflow=1 after the 9th frame. Draining yields 01..08, then ready=0. overflow stays 1 until clrn.
- Assert clrn low after 5 bits of a frame, release, send 8'h2A -> data=8'h2A, ready=1.
- Hold nextdata_n low while a frame completes into an empty FIFO -> the byte is popped the cycle after ready rises; no spurious pop occurs while empty.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and frame checking for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam int PS2_FRAME_BITS      = 11;
    localparam int START_IDX           = 0;
    localparam int PARITY_IDX          = 9;
    localparam int STOP_IDX            = 10;
    localparam int DEFAULT_FIFO_DEPTH  = 8;
    localparam int DEFAULT_SYNC_STAGES = 3;

    // head holds start, d0..d7 and parity; stop is the bit being sampled right now.
    function automatic logic frame_ok(input logic [PS2_FRAME_BITS-2:0] head, input logic stop);
        return (head[START_IDX] == 1'b0) && stop && (^head[PARITY_IDX:START_IDX+1]);
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous byte FIFO for received scan codes; head is read combinationally.
module ps2_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_push;
    logic             do_pop;

    assign empty     = (occ == '0);
    assign full      = (occ == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    // A pop on the same edge frees the slot the push lands in.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: oversampled ps2_clk, 11-bit deframing, byte FIFO.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow
);

    localparam logic [3:0] LAST_CNT = 4'(STOP_IDX);

    logic [SYNC_STAGES-1:0]    clk_sync;
    logic [3:0]                count;
    logic [PS2_FRAME_BITS-2:0] buffer;
    logic                      fall;
    logic                      frame_end;
    logic                      push;
    logic                      pop_req;
    logic                      fifo_empty;
    logic                      fifo_full;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) clk_sync <= '1;
        else       clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
    end

    assign fall      = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    assign frame_end = fall && (count == LAST_CNT);
    assign push      = frame_end && frame_ok(buffer, ps2_data);

    // Only a clean 0 counts as a read request; X or 1 never pops.
    always_comb begin
        pop_req = 1'b0;
        if (nextdata_n == 1'b0) pop_req = 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count  <= '0;
            buffer <= '0;
        end else if (fall) begin
            if (count == LAST_CNT) begin
                count <= '0;
            end else begin
                buffer[count] <= ps2_data;
                count         <= count + 1'b1;
            end
        end
    end

    // full implies non-empty, so pop_req here is a pop that actually frees a slot.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                                 overflow <= 1'b0;
        else if (push && fifo_full && !pop_req)    overflow <= 1'b1;
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (push),
        .push_data (buffer[8:1]),
        .pop       (pop_req),
        .head_data (data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign ready = ~fifo_empty;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: directed scenarios plus randomized frames against a queue model.
module tb_ps2_keyboard;

    localparam int DEPTH = 8;

    logic       clk        = 1'b0;
    logic       clrn       = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;

    always #5 clk = ~clk;

    ps2_keyboard #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One PS/2 bit: data set while clock high, 30 ns low phase, 30 ns high phase.
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #12 ps2_clk = 1'b0;
        #30 ps2_clk = 1'b1;
        #18;
    endtask

    // err: 0 good, 1 parity flipped, 2 start=1, 3 stop=0
    task automatic send_frame(input logic [7:0] d, input int err);
        logic [10:0] f;
        f[0]   = (err == 2);
        f[8:1] = d;
        f[9]   = ~(^d) ^ (err == 1);
        f[10]  = (err != 3);
        @(negedge clk);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        repeat (2) @(negedge clk);
        if (err == 0) begin
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else                        model_ovf = 1'b1;
        end
    endtask

    task automatic pop_one();
        @(negedge clk) nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ready !== 1'b0)     begin n_err++; $display("FAIL reset_ready: got %0b want 0", ready); end
        n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        n_cmp++; if (data !== 8'h00)     begin n_err++; $display("FAIL reset_data: got %02h want 00", data); end
    endtask

    task automatic test_single();
        send_frame(8'hFD, 0);
        n_cmp++; if (ready !== 1'b1)     begin n_err++; $display("FAIL single_ready: got %0b want 1", ready); end
        n_cmp++; if (data !== 8'hFD)     begin n_err++; $display("FAIL single_data: got %02h want FD", data); end
        n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL single_overflow: got %0b want 0", overflow); end
        @(negedge clk) nextdata_n = 1'b0;
        repeat (2) @(negedge clk);
        nextdata_n = 1'b1;
        if (model_q.size() > 0) void'(model_q.pop_front());
        n_cmp++; if (ready !== 1'b0)     begin n_err++; $display("FAIL single_drain_ready: got %0b want 0", ready); end
    endtask

    task automatic test_sequence();
        logic [7:0] seq [4] = '{8'h1C, 8'hF0, 8'h1C, 8'h1B};
        for (int i = 0; i < 4; i++) send_frame(seq[i], 0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL seq_ready[%0d]: got %0b want 1", i, ready); end
            n_cmp++; if (data !== seq[i]) begin n_err++; $display("FAIL seq_data[%0d]: got %02h want %02h", i, data, seq[i]); end
            pop_one();
        end
        n_cmp++; if (ready !== 1'b0)     begin n_err++; $display("FAIL seq_empty_ready: got %0b want 0", ready); end
    endtask

    task automatic test_bad_frames();
        for (int e = 1; e <= 3; e++) begin
            send_frame(8'h1C, e);
            n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL bad_frame_ready[err%0d]: got %0b want 0", e, ready); end
        end
        send_frame(8'h1B, 0);
        n_cmp++; if (ready !== 1'b1)     begin n_err++; $display("FAIL bad_then_good_ready: got %0b want 1", ready); end
        n_cmp++; if (data !== 8'h1B)     begin n_err++; $display("FAIL bad_then_good_data: got %02h want 1B", data); end
        pop_one();
    endtask

    task automatic test_pop_while_waiting();
        int hi_cycles = 0;
        @(negedge clk) nextdata_n = 1'b0;
        fork
            send_frame(8'h5A, 0);
            begin
                for (int c = 0; c < 200; c++) begin
                    @(negedge clk);
                    if (ready === 1'b1) hi_cycles++;
                end
            end
        join
        nextdata_n = 1'b1;
        if (model_q.size() > 0) void'(model_q.pop_front());
        n_cmp++; if (hi_cycles != 1)     begin n_err++; $display("FAIL held_pop_ready_cycles: got %0d want 1", hi_cycles); end
        n_cmp++; if (ready !== 1'b0)     begin n_err++; $display("FAIL held_pop_ready_after: got %0b want 0", ready); end
        send_frame(8'h77, 0);
        n_cmp++; if (data !== 8'h77)     begin n_err++; $display("FAIL held_pop_next_data: got %02h want 77", data); end
        pop_one();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 0);
            if (i == 8) begin
                n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_full: got %0b want 0", overflow); end
            end
        end
        n_cmp++; if (overflow !== model_ovf) begin n_err++; $display("FAIL ovf_after_9: got %0b want %0b", overflow, model_ovf); end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (data !== 8'(i)) begin n_err++; $display("FAIL ovf_drain[%0d]: got %02h want %02h", i, data, 8'(i)); end
            pop_one();
        end
        n_cmp++; if (ready !== 1'b0)     begin n_err++; $display("FAIL ovf_drained_ready: got %0b want 0", ready); end
        send_frame(8'h33, 0);
        n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
        n_cmp++; if (data !== 8'h33)     begin n_err++; $display("FAIL ovf_post_data: got %02h want 33", data); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'h55;
        @(negedge clk);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(d[i]);
        @(negedge clk) clrn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL midrst_overflow: got %0b want 0", overflow); end
        n_cmp++; if (ready !== 1'b0)     begin n_err++; $display("FAIL midrst_ready: got %0b want 0", ready); end
        clrn = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        send_frame(8'h2A, 0);
        n_cmp++; if (ready !== 1'b1)     begin n_err++; $display("FAIL midrst_next_ready: got %0b want 1", ready); end
        n_cmp++; if (data !== 8'h2A)     begin n_err++; $display("FAIL midrst_next_data: got %02h want 2A", data); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            int err;
            int npop;
            d    = 8'($urandom_range(0, 255));
            err  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_frame(d, err);
            n_cmp++; if (ready !== (model_q.size() > 0)) begin n_err++; $display("FAIL rand_ready[%0d]: got %0b want %0b", n, ready, model_q.size() > 0); end
            n_cmp++; if (overflow !== model_ovf) begin n_err++; $display("FAIL rand_overflow[%0d]: got %0b want %0b", n, overflow, model_ovf); end
            npop = $urandom_range(0, 1);
            for (int p = 0; p < npop; p++) begin
                if (model_q.size() > 0) begin
                    n_cmp++; if (data !== model_q[0]) begin n_err++; $display("FAIL rand_data[%0d]: got %02h want %02h", n, data, model_q[0]); end
                end
                pop_one();
            end
        end
        while (model_q.size() > 0) begin
            n_cmp++; if (data !== model_q[0]) begin n_err++; $display("FAIL rand_drain: got %02h want %02h", data, model_q[0]); end
            pop_one();
        end
        n_cmp++; if (ready !== 1'b0)     begin n_err++; $display("FAIL rand_final_ready: got %0b want 0", ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_bad_frames();
        test_pop_while_waiting();
        test_overflow();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
